// File: rtl/sha512_padder.sv
// sha512_padder: byte-stream front end for the SHA-512 compression core.
// Collects message bytes into a 1024-bit big-endian chunk and applies
// FIPS 180-4 padding: 0x80 marker, zero fill, and a 128-bit bit-length.
// An extra chunk is emitted when the marker lands too late for the length.
module sha512_padder (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [7:0]    in_data,
  input  logic          in_last,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [1023:0] out_chunk,
  output logic          out_first,
  output logic          out_final
);

  typedef enum logic [1:0] {
    ST_FILL = 2'd0,
    ST_PAD  = 2'd1,
    ST_EMIT = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [1023:0] buffer_q, buffer_d;
  logic [7:0]    idx_q, idx_d;
  logic [60:0]   bytecnt_q, bytecnt_d;
  logic          first_q, first_d;
  logic          after_last_q, after_last_d;
  logic          pend80_q, pend80_d;
  logic          final_q, final_d;

  // LSB position of byte slot idx (slot 0 sits at the top of the chunk)
  function automatic logic [9:0] slot_lsb(input logic [7:0] idx);
    return 10'd1016 - {idx[6:0], 3'b000};
  endfunction

  // Next-state logic: byte capture, padding insertion and chunk handoff
  always_comb begin
    state_d      = state_q;
    buffer_d     = buffer_q;
    idx_d        = idx_q;
    bytecnt_d    = bytecnt_q;
    first_d      = first_q;
    after_last_d = after_last_q;
    pend80_d     = pend80_q;
    final_d      = final_q;
    case (state_q)
      ST_FILL: begin
        if (in_valid) begin
          buffer_d[slot_lsb(idx_q) +: 8] = in_data;
          idx_d     = idx_q + 8'd1;
          bytecnt_d = bytecnt_q + 61'd1;
          if (in_last) begin
            pend80_d = 1'b1;
            if (idx_q == 8'd127) begin
              // Chunk is full: marker and length go into a following chunk
              after_last_d = 1'b1;
              final_d      = 1'b0;
              state_d      = ST_EMIT;
            end else begin
              state_d = ST_PAD;
            end
          end else if (idx_q == 8'd127) begin
            after_last_d = 1'b0;
            final_d      = 1'b0;
            state_d      = ST_EMIT;
          end else begin
            state_d = ST_FILL;
          end
        end else begin
          state_d = ST_FILL;
        end
      end
      ST_PAD: begin
        pend80_d = 1'b0;
        if (pend80_q) begin
          buffer_d[slot_lsb(idx_q) +: 8] = 8'h80;
        end else begin
          buffer_d = buffer_q;
        end
        if (!pend80_q || (idx_q <= 8'd111)) begin
          // Length field fits: slots 112..127 carry the 128-bit bit count
          buffer_d[127:0] = {64'h0, bytecnt_q, 3'b000};
          final_d         = 1'b1;
        end else begin
          // Marker occupies the length area: length follows in another chunk
          final_d      = 1'b0;
          after_last_d = 1'b1;
        end
        state_d = ST_EMIT;
      end
      ST_EMIT: begin
        if (out_ready) begin
          buffer_d = '0;
          idx_d    = 8'd0;
          first_d  = 1'b0;
          final_d  = 1'b0;
          if (final_q) begin
            bytecnt_d    = 61'd0;
            after_last_d = 1'b0;
            first_d      = 1'b1;
            state_d      = ST_FILL;
          end else if (after_last_q) begin
            state_d = ST_PAD;
          end else begin
            state_d = ST_FILL;
          end
        end else begin
          state_d = ST_EMIT;
        end
      end
      default: begin
        state_d = ST_FILL;
      end
    endcase
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= ST_FILL;
      buffer_q     <= '0;
      idx_q        <= 8'd0;
      bytecnt_q    <= 61'd0;
      first_q      <= 1'b1;
      after_last_q <= 1'b0;
      pend80_q     <= 1'b0;
      final_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      buffer_q     <= buffer_d;
      idx_q        <= idx_d;
      bytecnt_q    <= bytecnt_d;
      first_q      <= first_d;
      after_last_q <= after_last_d;
      pend80_q     <= pend80_d;
      final_q      <= final_d;
    end
  end

  // Outputs are taken straight from registered state
  assign in_ready  = reset && (state_q == ST_FILL);
  assign out_valid = (state_q == ST_EMIT);
  assign out_chunk = buffer_q;
  assign out_first = first_q;
  assign out_final = final_q;

endmodule

// File: tb/tb_sha512_padder.sv
// Directed bench for sha512_padder with a padded-message scoreboard.
module tb_sha512_padder;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [7:0]    in_data;
  logic          in_last;
  logic          out_valid;
  logic          out_ready;
  logic [1023:0] out_chunk;
  logic          out_first;
  logic          out_final;

  typedef struct {
    logic [1023:0] chunk;
    logic          first;
    logic          fin;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] msg[$];
  int         vectors = 0;
  int         miscompares = 0;

  always #5 clk = ~clk;

  sha512_padder dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_chunk (out_chunk),
    .out_first (out_first),
    .out_final (out_final)
  );

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp_v);
    vectors++;
    assert (obs === exp_v) else begin
      miscompares++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp_v);
    end
  endtask

  // Reference padding of msg into expected chunks
  task automatic push_expect();
    int         len = msg.size();
    int         total = ((len + 17 + 127) / 128) * 128;
    logic [7:0] p[$];
    logic [127:0] bl;
    exp_t       e;
    p = msg;
    p.push_back(8'h80);
    while (p.size() < total - 16) p.push_back(8'h00);
    bl = 128'(len) << 3;
    for (int i = 0; i < 16; i++) p.push_back(bl[127 - 8*i -: 8]);
    for (int c = 0; c < total / 128; c++) begin
      e.chunk = '0;
      for (int k = 0; k < 128; k++) e.chunk[1023 - 8*k -: 8] = p[c*128 + k];
      e.first = (c == 0);
      e.fin   = (c == total / 128 - 1);
      sb.push_back(e);
    end
  endtask

  task automatic send_byte(input logic [7:0] d, input logic last);
    int n = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    while (!in_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      chk("in_ready_timeout", in_ready, 1'b1);
      $fatal(1, "stalled input");
    end
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic send_msg(input logic push);
    for (int i = 0; i < msg.size(); i++) send_byte(msg[i], i == msg.size() - 1);
    if (push) push_expect();
  endtask

  task automatic collect(input int hold, input string tag);
    int   n = 0;
    exp_t e;
    while (!out_valid && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_valid"}, out_valid, 1'b1);
    chk({tag, "_sb_nonempty"}, sb.size() != 0, 1'b1);
    if (out_valid && sb.size() != 0) begin
      e = sb[0];
      for (int h = 0; h < hold; h++) begin
        chk({tag, "_hold_hi"}, out_chunk[1023:512], e.chunk[1023:512]);
        chk({tag, "_hold_lo"}, out_chunk[511:0], e.chunk[511:0]);
        chk({tag, "_hold_first"}, out_first, e.first);
        chk({tag, "_hold_final"}, out_final, e.fin);
        chk({tag, "_hold_valid"}, out_valid, 1'b1);
        chk({tag, "_hold_in_ready"}, in_ready, 1'b0);
        @(negedge clk);
      end
      chk({tag, "_hi"}, out_chunk[1023:512], e.chunk[1023:512]);
      chk({tag, "_lo"}, out_chunk[511:0], e.chunk[511:0]);
      chk({tag, "_first"}, out_first, e.first);
      chk({tag, "_final"}, out_final, e.fin);
      chk({tag, "_in_ready"}, in_ready, 1'b0);
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      out_ready = 1'b0;
      void'(sb.pop_front());
      chk({tag, "_handoff"}, out_valid, 1'b0);
    end
  endtask

  initial begin
    reset     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    in_last   = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_chunk_hi", out_chunk[1023:512], '0);
    chk("rst_chunk_lo", out_chunk[511:0], '0);
    chk("rst_out_first", out_first, 1'b1);
    chk("rst_out_final", out_final, 1'b0);
    chk("rst_in_ready", in_ready, 1'b0);
    reset = 1'b1;
    @(negedge clk);
    chk("post_rst_in_ready", in_ready, 1'b1);

    // "abc": final chunk two cycles after the last byte
    msg = {8'h61, 8'h62, 8'h63};
    send_msg(1'b1);
    chk("abc_pad_cycle", out_valid, 1'b0);
    @(negedge clk);
    chk("abc_latency", out_valid, 1'b1);
    collect(0, "abc");

    // 111 bytes: marker at slot 111, length still fits
    msg.delete();
    for (int i = 0; i < 111; i++) msg.push_back(8'hAA);
    send_msg(1'b1);
    collect(0, "m111");

    // 112 bytes: extra length chunk, first chunk held off for 5 cycles
    msg.delete();
    for (int i = 0; i < 112; i++) msg.push_back(8'hAA);
    send_msg(1'b1);
    collect(5, "m112_c1");
    collect(0, "m112_c2");

    // 128 bytes: pure data chunk then marker+length chunk
    msg.delete();
    for (int i = 0; i < 128; i++) msg.push_back(8'(i));
    send_msg(1'b1);
    chk("m128_latency", out_valid, 1'b1);
    collect(0, "m128_c1");
    collect(0, "m128_c2");

    // Reset in the middle of a message, then "abc" again
    msg.delete();
    for (int i = 0; i < 50; i++) msg.push_back(8'h5A);
    send_msg(1'b0);
    reset = 1'b0;
    @(negedge clk);
    chk("midrst_in_ready", in_ready, 1'b0);
    chk("midrst_first", out_first, 1'b1);
    chk("midrst_valid", out_valid, 1'b0);
    reset = 1'b1;
    @(negedge clk);
    msg = {8'h61, 8'h62, 8'h63};
    send_msg(1'b1);
    chk("abc2_pad_cycle", out_valid, 1'b0);
    @(negedge clk);
    chk("abc2_latency", out_valid, 1'b1);
    collect(0, "abc2");

    chk("sb_drained", sb.size() == 0, 1'b1);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/sha512_padder.md
# sha512_padder

Byte-stream front end for the SHA-512 datapath: accepts a message one byte at a time and emits big-endian, FIPS 180-4 padded 1024-bit chunks for the `sha512_chunk` compression core. It appends the 0x80 marker, zero fill and the 128-bit message bit-length, inserting an extra chunk when the length field does not fit. It also flags the first and final chunk of each message so the sequencer can load the initial H values and latch the digest.

## Interface
- No parameters. The bit-length field is 128 bits; the upper 64 bits are always zero, and the lower 64 bits count modulo 2^64.
- `clk`  in  1  sole clock; all logic on the rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `in_valid`  in  1  `in_data` / `in_last` are valid.
- `in_ready`  out  1  padder accepts a byte this cycle.
- `in_data`  in  8  message byte.
- `in_last`  in  1  this byte is the final byte of the message. Zero-length messages are not supported.
- `out_valid`  out  1  `out_chunk` holds a complete chunk.
- `out_ready`  in  1  consumer takes the chunk.
- `out_chunk`  out  1024  chunk; message byte k of the chunk sits at `[1023-8k -: 8]`.
- `out_first`  out  1  chunk is the first of its message.
- `out_final`  out  1  chunk is the last of its message.

## Operation
- **Registers**
  - buffer[1023:0]
  - idx[7:0] (next byte slot, 0..128)
  - bytecnt[60:0]
  - flags `first`, `after_last`, `pend80`, `final`
- **FILL**
  - `in_ready` = 1.
  - On accept, write `in_data` to slot idx, then idx+1 and bytecnt+1.
  - `in_last` with idx+1 ≤ 127 → PAD (`pend80` = 1).
  - `in_last` with idx = 127 → EMIT (`after_last` = 1, `pend80` = 1, `final` = 0).
  - Non-last with idx = 127 → EMIT (`after_last` = 0, `final` = 0).
- **PAD** (1 cycle, `in_ready` = 0)
  - If `pend80`, write 0x80 at slot idx; clear `pend80`.
  - If the marker was written and idx ≤ 111, or no marker was written: write {64'h0, bytecnt·8} into slots 112..127, set `final` = 1, go to EMIT.
  - Otherwise (marker at idx 112..127): go to EMIT with `final` = 0 and `after_last` = 1.
- **EMIT**
  - `out_valid` = 1 and `in_ready` = 0.
  - On `out_valid && out_ready`: buffer ← 0, idx ← 0, `first` ← 0.
  - If `final`: clear bytecnt and `after_last`, set `first` = 1, go to FILL.
  - Else if `after_last`: go to PAD.
  - Else: go to FILL.
- Unwritten slots are zero by construction, because the buffer is cleared on every chunk handoff.
- **Arithmetic:** bit-length = {bytecnt, 3'b000} zero-extended to 128 bits. bytecnt includes the `in_last` byte.

## Timing
- **Reset** (`reset` low at a rising edge):
  - State FILL; buffer, idx, bytecnt cleared; `first` = 1.
  - `out_valid` = 0, `out_chunk` = 0, `out_first` = 1, `out_final` = 0.
  - `in_ready` is forced to 0 while `reset` is low.
  - A partial message or pending chunk is discarded.
- **Handshakes:** a transfer occurs on `valid && ready` at a rising edge. `in_ready` and `out_valid` are mutually exclusive.
- **Hold:** `out_chunk`, `out_first` and `out_final` are stable while `out_valid && !out_ready`.
- **Latency**
  - Full data chunk: `out_valid` rises the cycle after the 128th byte is accepted.
  - Final chunk: `out_valid` rises 2 cycles after the `in_last` byte (via PAD).
  - Extra length chunk: 1 cycle (PAD) after the preceding chunk handoff.
- **Throughput:** at most one byte per cycle. With `out_ready` tied high, 1 bubble per 128-byte chunk.
- **Back-to-back messages:** a new message may begin the cycle after the final chunk handoff.

## Test plan
- **"abc"** (0x61, 0x62, 0x63 + `in_last`) → one chunk:
  - `[1023:992]` = 0x61626380 and `[63:0]` = 0x18, all else 0.
  - `out_first` = 1, `out_final` = 1.
  - `out_valid` asserted 2 cycles after the last byte.
- **111 bytes of 0xAA** → single chunk: slot 111 = 0x80, `[63:0]` = 0x378, `out_final` = 1.
- **112 bytes of 0xAA** → two chunks:
  - Chunk 1: slot 112 = 0x80, slots 113..127 = 0, `out_first` = 1, `out_final` = 0.
  - Chunk 2: all zero except `[63:0]` = 0x380, `out_first` = 0, `out_final` = 1.
- **128 bytes 0x00..0x7F** → two chunks:
  - Chunk 1: pure data, `out_final` = 0.
  - Chunk 2: slot 0 = 0x80, `[63:0]` = 0x400, `out_final` = 1.
- **Backpressure:** hold `out_ready` low 5 cycles during EMIT → `out_chunk` and flags unchanged, `in_ready` = 0 throughout; the handoff occurs on the cycle `out_ready` rises.
- **Reset mid-message:** pulse `reset` low after 50 bytes, then send "abc" → output identical to scenario 1; `out_first` = 1 and the bit-length is 0x18.
